// File: rtl/fp_arith_pkg.sv
// Shared helpers for the fixed-point arithmetic library:
// Q-format widths, saturation limits and the iterative-unit state set.
package fp_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FINAL,
    ST_DONE
  } iter_state_e;

  function automatic int q_width(input int i, input int f);
    return i + f;
  endfunction

  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// subtract the divisor when it fits.
module fp_div_step #(
  parameter int W = 15
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_den,
  input  logic         i_bit,
  output logic [W-1:0] o_rem,
  output logic         o_q
);

  logic [W:0]   w_sh;
  logic [W-1:0] w_diff;

  assign w_sh   = {i_rem, i_bit};
  assign o_q    = (w_sh >= {1'b0, i_den});
  // the difference is always below the divisor, so W bits suffice
  assign w_diff = w_sh[W-1:0] - i_den;
  assign o_rem  = o_q ? w_diff : w_sh[W-1:0];

endmodule

// File: rtl/fp_div.sv
// Sequential signed fixed-point divider, one quotient bit per cycle.
// Define FP_DIV_ROUND_EN for round-half-away-from-zero.
module fp_div
  import fp_arith_pkg::*;
#(
  parameter int int1     = 6,
  parameter int frac1    = 8,
  parameter int int2     = 6,
  parameter int frac2    = 8,
  parameter int out_int  = 6,
  parameter int out_frac = 12
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [q_width(int1,frac1)-1:0]    a,
  input  logic [q_width(int2,frac2)-1:0]    b,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [q_width(out_int,out_frac)-1:0] quotient,
  output logic                              overflow,
  output logic                              div_by_zero
);

  localparam int AW   = q_width(int1, frac1);
  localparam int BW   = q_width(int2, frac2);
  localparam int OW   = q_width(out_int, out_frac);
  localparam int SH   = out_frac + frac2 - frac1;
  localparam int ITER = AW + SH;
  localparam int DW   = BW + 1;
  localparam int CW   = $clog2(ITER);
  localparam logic [63:0] MAXP = sat_max(OW);
  localparam logic [63:0] MINN = sat_min(OW);

  if (SH < 0) begin : g_bad_fmt
    $error("fp_div: out_frac+frac2-frac1 must be >= 0");
  end

  iter_state_e r_state, w_state_nx;

  logic            r_sign;
  logic [ITER-1:0] r_num;
  logic [DW-1:0]   r_den;
  logic [DW-1:0]   r_rem;
  logic [CW-1:0]   r_cnt;
  logic [OW-1:0]   r_quo;
  logic            r_ovf;
  logic            r_dz;

  logic [AW:0]     w_a_ext, w_a_abs;
  logic [DW-1:0]   w_b_ext, w_b_abs;
  logic [ITER-1:0] w_n0;
  logic            w_bz;
  logic            w_acc;
  logic [DW-1:0]   w_rem_nx;
  logic            w_q;
  logic [ITER:0]   w_mq;
  logic [ITER:0]   w_lim;
  logic [OW-1:0]   w_mq_lo;
  logic [OW-1:0]   w_sat;

  // one extra bit so the most negative operand has a magnitude
  assign w_a_ext = {a[AW-1], a};
  assign w_a_abs = a[AW-1] ? -w_a_ext : w_a_ext;
  assign w_b_ext = {b[BW-1], b};
  assign w_b_abs = b[BW-1] ? -w_b_ext : w_b_ext;
  assign w_n0    = ITER'(w_a_abs) << SH;
  assign w_bz    = (b == '0);
  assign w_acc   = in_valid & in_ready;

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign quotient    = r_quo;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dz;

  fp_div_step #(.W(DW)) u_step (
    .i_rem (r_rem),
    .i_den (r_den),
    .i_bit (r_num[ITER-1]),
    .o_rem (w_rem_nx),
    .o_q   (w_q)
  );

`ifdef FP_DIV_ROUND_EN
  logic w_rnd;
  assign w_rnd = ({r_rem, 1'b0} >= {1'b0, r_den});
  assign w_mq  = {1'b0, r_num} + {{ITER{1'b0}}, w_rnd};
`else
  assign w_mq  = {1'b0, r_num};
`endif

  assign w_lim   = r_sign ? MINN[ITER:0] : MAXP[ITER:0];
  assign w_mq_lo = w_mq[OW-1:0];
  assign w_sat   = r_sign ? MINN[OW-1:0] : MAXP[OW-1:0];

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:
        if (in_valid) w_state_nx = w_bz ? ST_DONE : ST_CALC;
      ST_CALC:
        if (r_cnt == '0) w_state_nx = ST_FINAL;
      ST_FINAL:
        w_state_nx = ST_DONE;
      ST_DONE:
        if (out_ready) w_state_nx = ST_IDLE;
      default:
        w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sign <= 1'b0;
      r_num  <= '0;
      r_den  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_ovf  <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_sign <= a[AW-1] ^ b[BW-1];
        r_num  <= w_n0;
        r_den  <= w_b_abs;
        r_rem  <= '0;
        r_cnt  <= CW'(ITER - 1);
        if (w_bz) begin
          r_quo <= a[AW-1] ? MINN[OW-1:0] : MAXP[OW-1:0];
          r_dz  <= 1'b1;
          r_ovf <= 1'b0;
        end
      end
      if (r_state == ST_CALC) begin
        // quotient bits shift into the vacated dividend positions
        r_rem <= w_rem_nx;
        r_num <= {r_num[ITER-2:0], w_q};
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == ST_FINAL) begin
        r_dz <= 1'b0;
        if (w_mq > w_lim) begin
          r_quo <= w_sat;
          r_ovf <= 1'b1;
        end else begin
          r_quo <= r_sign ? -w_mq_lo : w_mq_lo;
          r_ovf <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Bench for fp_div: integer-arithmetic reference model plus
// hand-computed literals, latency, hold and reset-abort checks.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, overflow, div_by_zero;
  logic [13:0] t_a = '0, t_b = '0;
  logic [17:0] quotient;

  int          n_vec = 0;
  int          n_err = 0;
  logic [17:0] exp_q = '0;
  logic        exp_ovf = 1'b0;
  logic        exp_dz = 1'b0;

`ifdef FP_DIV_ROUND_EN
  localparam logic [17:0] Q_2_3 = 18'h00AAB;
`else
  localparam logic [17:0] Q_2_3 = 18'h00AAA;
`endif

  always #5 clk = ~clk;

  fp_div dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (t_a),
    .b           (t_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  // quotient = a/b scaled by 2^12 (Q6.8 / Q6.8 -> Q6.12)
  function automatic void model(
    input  logic [13:0] ma,
    input  logic [13:0] mb,
    output logic [17:0] q,
    output logic        ovf,
    output logic        dz
  );
    longint av, bv, am, bm, m, rm, lim;
    logic   neg;
    av  = longint'($signed(ma));
    bv  = longint'($signed(mb));
    ovf = 1'b0;
    dz  = 1'b0;
    if (bv == 0) begin
      dz = 1'b1;
      q  = (av < 0) ? 18'h20000 : 18'h1FFFF;
      return;
    end
    am = (av < 0) ? -av : av;
    bm = (bv < 0) ? -bv : bv;
    m  = (am * 4096) / bm;
    rm = (am * 4096) % bm;
`ifdef FP_DIV_ROUND_EN
    if (2 * rm >= bm) m = m + 1;
`endif
    neg = (av < 0) != (bv < 0);
    lim = neg ? 131072 : 131071;
    if (m > lim) begin
      ovf = 1'b1;
      q   = neg ? 18'h20000 : 18'h1FFFF;
    end else begin
      q = neg ? 18'(-m) : 18'(m);
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // every cycle a result is presented it must match the model and hold
  always @(negedge clk) begin
    if (reset && out_valid) begin
      n_vec++;
      if (quotient !== exp_q || overflow !== exp_ovf ||
          div_by_zero !== exp_dz || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL result: got q=%h ovf=%b dz=%b rdy=%b want q=%h ovf=%b dz=%b rdy=0",
                 quotient, overflow, div_by_zero, in_ready,
                 exp_q, exp_ovf, exp_dz);
      end
    end
  end

  task automatic run_op(
    input logic [13:0] va,
    input logic [13:0] vb,
    input logic        lit,
    input logic [17:0] lq,
    input logic        lovf,
    input logic        ldz,
    input int          hold
  );
    int   cyc;
    logic seen;
    model(va, vb, exp_q, exp_ovf, exp_dz);
    @(negedge clk);
    t_a = va;
    t_b = vb;
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    t_a = ~va;
    t_b = vb ^ 14'h0100;
    cyc = 0;
    seen = out_valid;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= 3) in_valid = 1'b0;
      seen = out_valid;
    end
    in_valid = 1'b0;
    chk("valid_seen", seen, 1);
    chk("latency", cyc, (vb == 0) ? 0 : 27);
    if (lit) begin
      chk("lit_q", quotient, lq);
      chk("lit_ovf", overflow, lovf);
      chk("lit_dz", div_by_zero, ldz);
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("drain_q", quotient, exp_q);
    chk("drain_rdy", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_q", quotient, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_dz", div_by_zero, 0);
    reset = 1'b1;

    run_op(14'h0300, 14'h0180, 1, 18'h02000, 0, 0, 0);
    run_op(14'h3D00, 14'h0180, 1, 18'h3E000, 0, 0, 1);
    run_op(14'h3D00, 14'h3E80, 1, 18'h02000, 0, 0, 0);
    run_op(14'h1F00, 14'h0001, 1, 18'h1FFFF, 1, 0, 2);
    run_op(14'h2100, 14'h0001, 1, 18'h20000, 1, 0, 0);
    run_op(14'h0100, 14'h0000, 1, 18'h1FFFF, 0, 1, 0);
    run_op(14'h3F00, 14'h0000, 1, 18'h20000, 0, 1, 3);
    run_op(14'h0200, 14'h0300, 1, Q_2_3, 0, 0, 0);
    run_op(14'h2000, 14'h0100, 1, 18'h20000, 0, 0, 0);
    run_op(14'h2000, 14'h3F00, 1, 18'h1FFFF, 1, 0, 0);
    run_op(14'h0000, 14'h3E80, 1, 18'h00000, 0, 0, 0);
    run_op(14'h1234, 14'h0567, 0, '0, 0, 0, 0);
    run_op(14'h2ABC, 14'h00FF, 0, '0, 0, 0, 1);
    run_op(14'h0001, 14'h3FFF, 0, '0, 0, 0, 0);
    run_op(14'h0300, 14'h0180, 1, 18'h02000, 0, 0, 5);

    // abort an operation mid-calculation
    model(14'h0300, 14'h0180, exp_q, exp_ovf, exp_dz);
    @(negedge clk);
    t_a = 14'h0300;
    t_b = 14'h0180;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("abort_rdy", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_q", quotient, 0);
    chk("abort_ovf", overflow, 0);
    chk("abort_dz", div_by_zero, 0);
    repeat (35) @(posedge clk);
    #1;
    chk("abort_no_result", out_valid, 0);

    run_op(14'h3D00, 14'h0180, 1, 18'h3E000, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
